// File: rtl/ctrl_pipe_regi.sv
// Control-bundle pipeline: DEPTH registered stages with valid bits, per-stage flush/hold,
// backward stall propagation and bubble collapse. Define PIPE_PERF_CNT_EN for stall/flush counters.
module ctrl_pipe_regi #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 3,
  parameter int unsigned ZERO_ON_FLUSH = 1
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W         = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEPTH-1:0] hold,
  input  logic [DEPTH-1:0] flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [DEPTH-1:0] stage_valid
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] hold_eff;

  // Stall walks upstream only through stages holding a valid entry; bubbles absorb it.
  always_comb begin
    logic chain;
    chain    = 1'b0;
    hold_eff = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      chain       = hold[k] | (chain & valid_q[k]);
      hold_eff[k] = chain;
    end
  end

  // Per-stage next state: flush beats hold beats load.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush[0]) begin
      valid_d[0] = 1'b0;
      if (ZERO_ON_FLUSH != 0) data_d[0] = '0;
    end else if (!hold_eff[0]) begin
      data_d[0]  = in_data;
      valid_d[0] = in_valid;
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (flush[k]) begin
        valid_d[k] = 1'b0;
        if (ZERO_ON_FLUSH != 0) data_d[k] = '0;
      end else if (!hold_eff[k]) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1] & ~hold_eff[k-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) data_q[k] <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready    = ~hold_eff[0];
  assign out_data    = data_q[DEPTH-1];
  assign out_valid   = valid_q[DEPTH-1];
  assign stage_valid = valid_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; one flush event per edge regardless of stages killed.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((|(flush & valid_q)) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_regi.sv
// Scoreboard bench for ctrl_pipe_regi (WIDTH=8, DEPTH=3, ZERO_ON_FLUSH=1).
// Surviving accepted inputs are queued; each consumed output is popped and compared.
module tb_ctrl_pipe_regi;
  logic       clock;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] hold;
  logic [2:0] flush;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] stage_valid;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int         n_vec;
  int         n_err;
  logic       rdy_seen;
  logic [7:0] exp_v;
  logic [7:0] sb[$];

  ctrl_pipe_regi #(.WIDTH(8), .DEPTH(3), .ZERO_ON_FLUSH(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold       (hold),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .stage_valid(stage_valid)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, score consumption/acceptance, return just after posedge.
  task automatic cyc(input logic [7:0] d, input logic v, input logic [2:0] h,
                     input logic [2:0] f, input bit track);
    @(negedge clock);
    in_data  = d;
    in_valid = v;
    hold     = h;
    flush    = f;
    #1;
    rdy_seen = in_ready;
    if (out_valid && !h[2]) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        exp_v = sb.pop_front();
        check("out_data", 32'(out_data), 32'(exp_v));
      end
    end
    if (v && in_ready && !f[0] && track) sb.push_back(d);
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    hold     = 3'b000;
    flush    = 3'b000;
    rdy_seen = 1'b0;
    #1 reset = 1'b0;
    #2;
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_stage_valid", 32'(stage_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    hold = 3'b001;
    #1;
    check("rst_in_ready_hold", 32'(in_ready), 32'h0);
    hold = 3'b000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Streaming and latency
    cyc(8'h11, 1'b1, 3'b000, 3'b000, 1'b1);
    check("lat_e0_valid", 32'(out_valid), 32'h0);
    cyc(8'h22, 1'b1, 3'b000, 3'b000, 1'b1);
    cyc(8'h33, 1'b1, 3'b000, 3'b000, 1'b1);
    check("lat_e2_valid", 32'(out_valid), 32'h1);
    check("lat_e2_data", 32'(out_data), 32'h11);
    check("steady_stage_valid", 32'(stage_valid), 32'h7);

    // Full pipeline A,B,C then downstream stall
    cyc(8'hA1, 1'b1, 3'b000, 3'b000, 1'b1);
    cyc(8'hB2, 1'b1, 3'b000, 3'b000, 1'b1);
    cyc(8'hC3, 1'b1, 3'b000, 3'b000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(8'hD4, 1'b1, 3'b100, 3'b000, 1'b1);
      check("stall_in_ready", 32'(rdy_seen), 32'h0);
      check("stall_out_data", 32'(out_data), 32'hA1);
      check("stall_stage_valid", 32'(stage_valid), 32'h7);
    end
    cyc(8'hD4, 1'b1, 3'b000, 3'b000, 1'b1);
    check("release_out_data", 32'(out_data), 32'hB2);

    // Bubble collapse: stage 1 empty while stage 2 stalls
    cyc(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
    cyc(8'hE5, 1'b1, 3'b000, 3'b000, 1'b1);
    check("bubble_pre_sv", 32'(stage_valid), 32'h5);
    cyc(8'hF6, 1'b1, 3'b100, 3'b000, 1'b1);
    check("bubble_in_ready", 32'(rdy_seen), 32'h1);
    check("bubble_sv", 32'(stage_valid), 32'h7);
    check("bubble_out_data", 32'(out_data), 32'hD4);

    // Flush stages 0 and 1 while stage 2 holds 0x55
    cyc(8'h55, 1'b1, 3'b000, 3'b000, 1'b1);
    cyc(8'h66, 1'b1, 3'b000, 3'b000, 1'b0);
    cyc(8'h77, 1'b1, 3'b000, 3'b000, 1'b0);
    cyc(8'h00, 1'b0, 3'b100, 3'b011, 1'b0);
    check("flush_sv", 32'(stage_valid), 32'h4);
    check("flush_out_data", 32'(out_data), 32'h55);
`ifdef PIPE_PERF_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'd2);
    check("flush_cnt", 32'(flush_cnt), 32'd1);
`endif
    cyc(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
    check("flush_zero_data", 32'(out_data), 32'h0);
    check("flush_zero_valid", 32'(out_valid), 32'h0);

    // Flush and hold on the same stage: flush wins, upstream still stalls once
    cyc(8'h81, 1'b1, 3'b000, 3'b000, 1'b0);
    cyc(8'h92, 1'b1, 3'b000, 3'b000, 1'b1);
    cyc(8'hA3, 1'b1, 3'b010, 3'b010, 1'b1);
    check("fh_in_ready", 32'(rdy_seen), 32'h0);
    check("fh_sv", 32'(stage_valid), 32'h1);
    cyc(8'hA3, 1'b1, 3'b000, 3'b000, 1'b1);
    check("fh_adv_sv", 32'(stage_valid), 32'h3);
    cyc(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
    check("fh_out_data", 32'(out_data), 32'h92);
    cyc(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
    cyc(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    // Asynchronous reset mid-stream
    cyc(8'hB1, 1'b1, 3'b000, 3'b000, 1'b1);
    cyc(8'hB2, 1'b1, 3'b000, 3'b000, 1'b1);
    cyc(8'hB3, 1'b1, 3'b000, 3'b000, 1'b1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_out_data", 32'(out_data), 32'h0);
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_stage_valid", 32'(stage_valid), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h1);
`ifdef PIPE_PERF_CNT_EN
    check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("arst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    sb.delete();
    @(negedge clock);
    reset = 1'b1;

    // Clean restart after reset
    cyc(8'hC7, 1'b1, 3'b000, 3'b000, 1'b1);
    cyc(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
    cyc(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
    check("restart_out_data", 32'(out_data), 32'hC7);
    cyc(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
    check("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe_regi.md
Name: ctrl_pipe_regi

Overview:
Parametrised control-signal pipeline register, successor to the single-stage ID/EX control latch. Carries a WIDTH-bit control bundle through DEPTH registered stages, each with a valid bit. Supports per-stage flush, per-stage hold with backward stall propagation, and bubble collapse. Sits between decode and the execute/memory/writeback stages; replaces the per-stage hand-written control latches.

Parameters:
WIDTH, 8, bits per control bundle (sw1..sw7 plus writeOrder packed LSB-first); minimum 1
DEPTH, 3, number of pipeline stages; minimum 1
ZERO_ON_FLUSH, 1, 1 = flushed stage data forced to 0; 0 = data left unchanged, only valid cleared
CNT_W, 16, width of the performance counters (optional feature only)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_data  in  WIDTH  control bundle from decode
in_valid  in  1  in_data holds a real instruction
in_ready  out  1  stage 0 can accept this cycle; equals !hold_eff[0]; combinational
hold  in  DEPTH  per-stage hold request; bit k = stage k must keep its contents
flush  in  DEPTH  per-stage kill; bit k = invalidate stage k at this edge
out_data  out  WIDTH  data[DEPTH-1]
out_valid  out  1  valid[DEPTH-1]
stage_valid  out  DEPTH  valid bit of every stage, bit k = stage k
stall_cnt  out  CNT_W  present only with PIPE_PERF_CNT_EN
flush_cnt  out  CNT_W  present only with PIPE_PERF_CNT_EN

Behaviour:
- Reset (reset==0, asynchronous): all data[k]=0, all valid[k]=0, counters=0. out_data=0, out_valid=0, stage_valid=0. in_ready reflects hold only; with hold=0 it is 1 during reset.
- Reset released mid-operation: all in-flight contents are lost, with no partial state. First capture happens at the first rising edge with reset==1.
- Effective hold, combinational, computed from current-cycle valid before any flush:
  - hold_eff[DEPTH-1] = hold[DEPTH-1]
  - hold_eff[k] = hold[k] | (hold_eff[k+1] & valid[k]), for k < DEPTH-1
  - A held stage only back-pressures upstream when it holds a valid entry. An invalid stage (bubble) absorbs the stall, so bubbles collapse.
- Per-stage update at each rising edge, in priority order:
  1. flush[k]=1: valid[k] is set to 0. If ZERO_ON_FLUSH=1, data[k] is set to 0; otherwise data[k] is unchanged. Flush overrides hold.
  2. Else hold_eff[k]=1: data[k] and valid[k] are unchanged.
  3. Else load from the source:
     - k=0: data<=in_data; valid<=in_valid.
     - k>0: data<=data[k-1]; valid<=valid[k-1] & !hold_eff[k-1]. A held upstream entry is never duplicated; a bubble enters stage k instead.
- Input handshake: an instruction is accepted when in_valid & in_ready.
  - If flush[0]=1 in the same cycle, the accepted instruction is discarded. The source must not resend it.
  - When in_ready=0, in_data is ignored.
- Latency: with no hold or flush, an instruction presented at edge N appears on out_data/out_valid after edge N+DEPTH-1. Example: DEPTH=3, accepted at edge 0, visible after edge 2. Throughput is 1 per cycle.
- hold[DEPTH-1] acts as the downstream not-ready signal. The consumer takes out_data when out_valid & !hold[DEPTH-1].
- Flush and hold on the same stage: flush wins. Upstream stages still see that stage's pre-flush valid in the hold_eff chain for this cycle. A stall propagated from a stage that is being flushed therefore still holds upstream for one cycle.
- DEPTH=1: behaves as the legacy single control latch, with hold and a valid bit added.
- No combinational path from in_data to out_data. in_ready depends combinationally on hold and the valid registers only.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each edge where in_valid & !in_ready.
  - flush_cnt increments once per edge when any k has flush[k] & valid[k]. It increments by 1 regardless of how many stages are killed.
  - Both counters saturate at 2^CNT_W-1 and clear only on reset.
- Undefined: the counters and their ports do not exist, and there is no added logic.

Test Plan (WIDTH=8, DEPTH=3, ZERO_ON_FLUSH=1):
1. Reset, then stream 0x11, 0x22, 0x33 with hold=0 and flush=0 -> out_valid rises after edge 2 with out_data=0x11, then 0x22, 0x33 on consecutive cycles; stage_valid=3'b111 at steady state.
2. Pipeline full with A, B, C (C in stage 0); set hold=3'b100 for 2 cycles -> in_ready=0, all stages frozen, out_data=A held; release hold -> B, C follow with no duplication and no loss.
3. Bubble collapse: stage 1 empty, stages 0 and 2 valid, hold=3'b100 for 1 cycle -> stage 0 entry advances into stage 1, in_ready=1 and a new input is accepted into stage 0; stage_valid=3'b111 afterwards.
4. flush=3'b011 while stages 0 and 1 are valid and stage 2 holds 0x55 -> after the edge stage_valid=3'b100, data[0]=data[1]=0, out_data=0x55 proceeds normally.
5. flush[1]=1 together with hold=3'b010 on a valid stage 1 -> stage 1 becomes invalid; stage 0 remains held this cycle and advances on the next edge.
6. Assert reset mid-stream with stages full -> all outputs are 0 asynchronously before the next edge. With PIPE_PERF_CNT_EN, stall_cnt=0 and flush_cnt=0, and the counts from scenarios 2 and 4 are correct before reset: stall_cnt=2, flush_cnt=1.
